// File: rtl/jtpopeye_pkg.sv
// Shared definitions for the Popeye text-layer RAM arbiter: write-buffer state
// encoding, slot constants and the scan-address helper.
package jtpopeye_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    localparam logic [2:0] SCAN_SLOT_DEF = 3'd5;
    localparam logic [7:0] VBL_START_DEF = 8'd224;

    // Fetch targets the next character cell; the column wraps inside the row.
    function automatic logic [9:0] scan_addr(input logic [7:0] h, input logic [7:0] v);
        logic [4:0] col;
        col = h[7:3] + 5'd1;
        return {v[7:3], col};
    endfunction

endpackage

// File: rtl/jtpopeye_txt_wbuf.sv
// One-entry posted write buffer for CPU text-RAM writes: captures each bus
// access once, holds it until a free slot commits it, stalls on overflow.
module jtpopeye_txt_wbuf
    import jtpopeye_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_cen_i,
    input  logic          cpu_req_i,
    input  logic [AW:0]   cpu_addr_i,
    input  logic [DW-1:0] cpu_din_i,
    input  logic          commit_i,
    output logic [AW:0]   buf_addr_o,
    output logic [DW-1:0] buf_data_o,
    output logic          full_o,
    output logic          cpu_wait_n_o
);

    logic [1:0]    state_q, state_d;
    logic          seen_q, seen_d;
    logic          wait_n_q, wait_n_d;
    logic [AW:0]   addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          new_acc;
    logic          load;

    assign new_acc = cpu_cen_i & cpu_req_i & ~seen_q;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d  = state_q;
        wait_n_d = wait_n_q;
        load     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (new_acc) begin
                    load    = 1'b1;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (commit_i) begin
                    // Old entry leaves as the new one arrives: no stall needed.
                    if (new_acc) load = 1'b1;
                    else         state_d = ST_IDLE;
                end else if (new_acc) begin
                    state_d  = ST_STALL;
                    wait_n_d = 1'b0;
                end
            end
            ST_STALL: begin
                if (commit_i) begin
                    wait_n_d = 1'b1;
                    if (cpu_req_i) begin
                        load    = 1'b1;
                        state_d = ST_FULL;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (cpu_cen_i && !cpu_req_i) begin
                    // Aborted bus cycle: the pending access is simply dropped.
                    state_d  = ST_FULL;
                    wait_n_d = 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                wait_n_d = 1'b1;
            end
        endcase
    end

    always_comb begin
        seen_d = seen_q;
        if (load)                         seen_d = 1'b1;
        else if (cpu_cen_i && !cpu_req_i) seen_d = 1'b0;
    end

    assign addr_d = load ? cpu_addr_i : addr_q;
    assign data_d = load ? cpu_din_i  : data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the payload is reset along with the control state so a discarded
            // entry never leaves stale data visible after reset.
            state_q  <= ST_IDLE;
            seen_q   <= 1'b0;
            wait_n_q <= 1'b1;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q  <= state_d;
            seen_q   <= seen_d;
            wait_n_q <= wait_n_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    assign buf_addr_o   = addr_q;
    assign buf_data_o   = data_q;
    assign full_o       = (state_q != ST_IDLE);
    assign cpu_wait_n_o = wait_n_q;

endmodule

// File: rtl/jtpopeye_txt_arb.sv
// Text-layer RAM arbiter: scan fetches own fixed slots of each character cell,
// buffered CPU writes are committed in the remaining slots or during blank.
module jtpopeye_txt_arb
    import jtpopeye_pkg::*;
#(
    parameter int         AW        = 10,
    parameter int         DW        = 8,
    parameter logic [7:0] VBL_START = VBL_START_DEF,
    parameter logic [2:0] SCAN_SLOT = SCAN_SLOT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pxl_cen,
    input  logic          cpu_cen,
    input  logic [7:0]    H,
    input  logic [7:0]    V,
    input  logic          cpu_req,
    input  logic [AW:0]   cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic          cpu_wait_n,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we_v,
    output logic          ram_we_c,
    output logic          scan_slot
);

    logic          scan_own;
    logic          commit;
    logic [AW:0]   buf_addr;
    logic [DW-1:0] buf_data;
    logic          buf_full;

    logic [AW-1:0] ram_addr_q;
    logic [DW-1:0] ram_din_q;
    logic          we_v_q, we_c_q, scan_slot_q;

    // The fetch slot and the one after it are reserved while the beam is visible.
    assign scan_own = ((H[2:0] == SCAN_SLOT) || (H[2:0] == SCAN_SLOT + 3'd1)) && (V < VBL_START);
    assign commit   = pxl_cen & buf_full & ~scan_own;

    jtpopeye_txt_wbuf #(
        .AW (AW),
        .DW (DW)
    ) u_wbuf (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_cen_i    (cpu_cen),
        .cpu_req_i    (cpu_req),
        .cpu_addr_i   (cpu_addr),
        .cpu_din_i    (cpu_din),
        .commit_i     (commit),
        .buf_addr_o   (buf_addr),
        .buf_data_o   (buf_data),
        .full_o       (buf_full),
        .cpu_wait_n_o (cpu_wait_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            we_v_q      <= 1'b0;
            we_c_q      <= 1'b0;
            scan_slot_q <= 1'b0;
        end else if (pxl_cen) begin
            if (commit) begin
                ram_addr_q  <= buf_addr[AW-1:0];
                ram_din_q   <= buf_data;
                we_v_q      <= ~buf_addr[AW];
                we_c_q      <= buf_addr[AW];
                scan_slot_q <= 1'b0;
            end else begin
                ram_addr_q  <= scan_addr(H, V);
                we_v_q      <= 1'b0;
                we_c_q      <= 1'b0;
                scan_slot_q <= scan_own;
            end
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign ram_we_v  = we_v_q;
    assign ram_we_c  = we_c_q;
    assign scan_slot = scan_slot_q;

endmodule

// File: tb/tb_jtpopeye_txt_arb.sv
// Directed bench for jtpopeye_txt_arb: stimulus pushes expected commits into a
// scoreboard, a negedge monitor pops and compares every RAM write pulse.
module tb_jtpopeye_txt_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        pxl_cen = 1'b1;
    logic        cpu_cen = 1'b1;
    logic [7:0]  H = 8'h00;
    logic [7:0]  V = 8'h00;
    logic        cpu_req = 1'b0;
    logic [10:0] cpu_addr = 11'h000;
    logic [7:0]  cpu_din = 8'h00;
    logic        cpu_wait_n;
    logic [9:0]  ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we_v;
    logic        ram_we_c;
    logic        scan_slot;

    jtpopeye_txt_arb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pxl_cen    (pxl_cen),
        .cpu_cen    (cpu_cen),
        .H          (H),
        .V          (V),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cpu_wait_n (cpu_wait_n),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we_v   (ram_we_v),
        .ram_we_c   (ram_we_c),
        .scan_slot  (scan_slot)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] h;
        logic [9:0] addr;
        logic [7:0] din;
        logic       we_v;
        logic       we_c;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] h_at_edge = 8'h00;

    always @(posedge clk) h_at_edge <= H;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] h, input logic [9:0] addr, input logic [7:0] din,
                            input logic we_v, input logic we_c);
        exp_t e;
        e.h = h; e.addr = addr; e.din = din; e.we_v = we_v; e.we_c = we_c;
        sb.push_back(e);
    endtask

    // Each tick presents the current H at one rising edge, then advances H.
    task automatic tick();
        @(posedge clk);
        #1;
        H = H + 8'd1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wait_n"},    cpu_wait_n, 1);
        check({tag, "_we_v"},      ram_we_v,   0);
        check({tag, "_we_c"},      ram_we_c,   0);
        check({tag, "_ram_addr"},  ram_addr,   0);
        check({tag, "_ram_din"},   ram_din,    0);
        check({tag, "_scan_slot"}, scan_slot,  0);
    endtask

    task automatic post_reset_scan(input string tag);
        V = 8'd16;
        H = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tick();
            check({tag, "_scan_slot"}, scan_slot, (i == 5 || i == 6));
        end
        check({tag, "_wait_n"}, cpu_wait_n, 1);
    endtask

    always @(negedge clk) begin
        if (rst_n && (ram_we_v || ram_we_c)) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%0h din 0x%0h we_v %0b we_c %0b at H 0x%0h, none expected",
                         ram_addr, ram_din, ram_we_v, ram_we_c, h_at_edge);
            end else begin
                mon_e = sb.pop_front();
                check("commit{h,addr,din,we_v,we_c}",
                      {h_at_edge, ram_addr, ram_din, ram_we_v, ram_we_c},
                      {mon_e.h, mon_e.addr, mon_e.din, mon_e.we_v, mon_e.we_c});
                check("commit_scan_slot", scan_slot, 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end of the test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Power-on reset, asserted between clock edges.
        #2 rst_n = 1'b0;
        #2 check_reset_values("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        post_reset_scan("por");

        // Write to 0x045 captured in slot 5: must wait out slots 5 and 6.
        H = 8'h25; V = 8'd16;
        cpu_addr = 11'h045; cpu_din = 8'h7E; cpu_req = 1'b1;
        push_exp(8'h27, 10'h045, 8'h7E, 1'b1, 1'b0);
        tick();
        check("t2_scan_addr_slot5", ram_addr, 10'h045);
        check("t2_scan_slot5", scan_slot, 1);
        check("t2_no_we_slot5", ram_we_v, 0);
        tick();
        check("t2_scan_slot6", scan_slot, 1);
        check("t2_no_we_slot6", ram_we_v, 0);
        tick();
        cpu_req = 1'b0;
        repeat (3) tick();

        // Colour write in vertical blank commits on the next pixel cycle.
        H = 8'h05; V = 8'd230;
        cpu_addr = 11'h412; cpu_din = 8'h0A; cpu_req = 1'b1;
        push_exp(8'h06, 10'h012, 8'h0A, 1'b0, 1'b1);
        tick();
        tick();
        check("t3_colour_nibble", ram_din[3:0], 4'hA);
        cpu_req = 1'b0;
        repeat (2) tick();

        // Second write while the first is still buffered stalls the CPU.
        H = 8'h2C; V = 8'd16;
        cpu_addr = 11'h0A1; cpu_din = 8'h11; cpu_req = 1'b1;
        push_exp(8'h2F, 10'h0A1, 8'h11, 1'b1, 1'b0);
        push_exp(8'h30, 10'h0A2, 8'h22, 1'b1, 1'b0);
        tick();
        cpu_req = 1'b0;
        tick();
        cpu_addr = 11'h0A2; cpu_din = 8'h22; cpu_req = 1'b1;
        tick();
        check("t4_stall_asserted", cpu_wait_n, 0);
        tick();
        check("t4_stall_released", cpu_wait_n, 1);
        tick();
        cpu_req = 1'b0;
        repeat (2) tick();

        // Capture and commit on the same edge: no loss, no stall.
        H = 8'h35; V = 8'd16;
        cpu_addr = 11'h155; cpu_din = 8'h33; cpu_req = 1'b1;
        push_exp(8'h37, 10'h155, 8'h33, 1'b1, 1'b0);
        push_exp(8'h38, 10'h156, 8'h44, 1'b1, 1'b0);
        tick();
        cpu_req = 1'b0;
        tick();
        cpu_addr = 11'h156; cpu_din = 8'h44; cpu_req = 1'b1;
        tick();
        check("t4b_no_stall", cpu_wait_n, 1);
        tick();
        cpu_req = 1'b0;
        repeat (2) tick();

        // Last cell of a row fetches column 0 of the same row.
        H = 8'hF8; V = 8'h40;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t5_wrap_addr", ram_addr, 10'h100);
            check("t5_wrap_scan_slot", scan_slot, (i == 5 || i == 6));
        end

        // One long-held request yields one write; a fresh request yields another.
        V = 8'd230;
        cpu_addr = 11'h3C0; cpu_din = 8'h5A; cpu_req = 1'b1;
        push_exp(H + 8'd1, 10'h3C0, 8'h5A, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cpu_cen = (i % 2 == 0);
            tick();
        end
        cpu_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cpu_cen = (i % 2 == 0);
            tick();
        end
        cpu_addr = 11'h7C1; cpu_din = 8'h5B; cpu_req = 1'b1;
        push_exp(H + 8'd1, 10'h3C1, 8'h5B, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cpu_cen = (i % 2 == 0);
            tick();
        end
        cpu_req = 1'b0;
        cpu_cen = 1'b1;
        repeat (2) tick();

        // Mid-frame reset with a write still buffered: the write is discarded.
        H = 8'h44; V = 8'd16;
        cpu_addr = 11'h3FF; cpu_din = 8'hFF; cpu_req = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1 check_reset_values("midframe");
        cpu_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        post_reset_scan("midframe");

        repeat (4) tick();
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
